l1_ahb_sram_slave: RTL and testbench
====================================

// Module: l1_ahb_sram_slave
// PURPOSE
//  AHB-Lite slave responder for the far end of an L1 bus-matrix output stage: receives HSEL/address/control
//  and HREADYMUX from the matrix, drives HREADYOUT/HRESP/HRDATA back. Bridges to a single-port synchronous
//  SRAM (1-cycle read latency). Inserts programmable wait states, raises two-cycle ERROR on illegal accesses.
// PARAMETERS
//  AW          12   SRAM word-address width (SRAM depth 2**AW words of 32 bits)
//  MEM_WORDS   4096 implemented words; word index >= MEM_WORDS -> ERROR (MEM_WORDS <= 2**AW)
//  WAIT_STATES 0    extra wait cycles per transfer, 0..7
// PORTS
//  HCLK        in   1   AHB clock; all logic on rising edge
//  HRESET      in   1   synchronous, active-high reset
//  HSELS       in   1   slave select from matrix
//  HADDRS      in   32  address
//  HTRANSS     in   2   transfer type (only bit[1] used: NONSEQ/SEQ)
//  HWRITES     in   1   1=write
//  HSIZES      in   3   transfer size
//  HREADYS     in   1   HREADYMUX from matrix (bus-wide transfer done)
//  HWDATAS     in   32  write data (data phase)
//  HREADYOUTS  out  1   slave ready
//  HRESPS      out  1   0=OKAY, 1=ERROR
//  HRDATAS     out  32  read data
//  sram_cs     out  1   SRAM chip select (1-cycle pulse)
//  sram_we     out  4   byte write enables (0000 = read)
//  sram_addr   out  AW  SRAM word address
//  sram_wdata  out  32  SRAM write data
//  sram_rdata  in   32  SRAM read data, valid cycle after read cs
// BEHAVIOUR
//  Reset (HRESET=1 at edge): state=IDLE, HREADYOUTS=1, HRESPS=0, HRDATAS=0, sram_cs=0, sram_we=0, counter=0.
//  Accept: addr phase taken when HSELS & HTRANSS[1] & HREADYS at a rising edge; capture addr, write, size.
//   IDLE/BUSY or HSELS=0 with HREADYS=1 -> IDLE, OKAY, zero wait. HREADYS=0 -> nothing sampled.
//  Error check at accept: HSIZES>2, HSIZES=1 & A[0], HSIZES=2 & A[1:0]!=0, or HADDRS[AW+1:2]>=MEM_WORDS -> ERR1.
//  FSM: IDLE, RD_ISSUE, RD_DATA, WR_WAIT, ERR1, ERR2. Wait counter wcnt 3b, loaded WAIT_STATES on accept.
//   IDLE: HREADYOUTS=1. Accept read -> RD_ISSUE; write -> WR_WAIT; error -> ERR1.
//   RD_ISSUE: HREADYOUTS=0; while wcnt!=0 decrement; when wcnt==0 drive sram_cs=1, sram_we=0,
//    sram_addr=captured A[AW+1:2] -> RD_DATA.
//   RD_DATA: HREADYOUTS=1, HRESPS=0, HRDATAS=sram_rdata (full word; master selects lanes). Then as IDLE
//    (new accept legal in this cycle). Read = WAIT_STATES+1 wait cycles.
//   WR_WAIT: HREADYOUTS=(wcnt==0); wcnt!=0 decrement. When wcnt==0: sram_cs=1, sram_we=lane mask,
//    sram_wdata=HWDATAS, completes this cycle -> as IDLE. Write = WAIT_STATES wait cycles.
//   Lane mask: size0 -> 1<<A[1:0]; size1 -> A[1]?1100:0011; size2 -> 1111. Little-endian.
//   ERR1: HREADYOUTS=0, HRESPS=1 -> ERR2. ERR2: HREADYOUTS=1, HRESPS=1 -> as IDLE. No SRAM access.
//  HRDATAS=0 in every cycle except RD_DATA. sram_cs/sram_we are 0 outside the cycles above.
//  SRAM touched only in data phase -> no address/data-phase port conflict; back-to-back W->R, R->W legal.
//  Transfer sampled in completing cycle (RD_DATA, WR_WAIT w/ wcnt==0, ERR2) starts its own data phase next.
//  Master abandoning after ERR1 (IDLE in ERR2 cycle) -> ERR2 completes normally, then IDLE.
//  Reset mid-transfer: outstanding access dropped, no SRAM strobe in the cycle after reset, outputs as reset.
//  HMASTLOCK/HBURST/HPROT not needed: each beat handled independently.
// TESTING
//  WAIT_STATES=0: write 0xDEADBEEF @0x10 then read @0x10 back-to-back -> write 0 waits, sram_we=1111 addr=4;
//   read 1 wait, HRDATAS=0xDEADBEEF, HRESPS=0.
//  Byte writes 0x11,0x22,0x33,0x44 @0x20..0x23, word read @0x20 -> we=0001,0010,0100,1000; data 0x44332211.
//  WAIT_STATES=3: read -> HREADYOUTS low 4 cycles; write -> low 3 cycles; sram_cs exactly one pulse each.
//  Halfword @0x01 and word @MEM_WORDS*4 -> HREADYOUTS 0 then 1 with HRESPS=1 both cycles; sram_cs never set.
//  HREADYS=0 with HSELS=1/NONSEQ -> not accepted; HTRANSS=IDLE -> OKAY zero wait; assert HRESET in RD_ISSUE
//   -> next cycle HREADYOUTS=1, HRESPS=0, sram_cs=0.

Source files
------------

// File: rtl/l1_ahb_sram_slave.sv
// rtl/l1_ahb_sram_slave.sv - AHB-Lite slave bridging to a 1-cycle-latency synchronous SRAM
// Programmable wait states, two-cycle ERROR response on misaligned or out-of-range accesses.
module l1_ahb_sram_slave #(
    parameter int AW          = 12,
    parameter int MEM_WORDS   = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSELS,
    input  logic [31:0]   HADDRS,
    input  logic [1:0]    HTRANSS,
    input  logic          HWRITES,
    input  logic [2:0]    HSIZES,
    input  logic          HREADYS,
    input  logic [31:0]   HWDATAS,
    output logic          HREADYOUTS,
    output logic          HRESPS,
    output logic [31:0]   HRDATAS,
    output logic          sram_cs,
    output logic [3:0]    sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_DATA,
        S_WR_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam logic [AW:0] MEM_LIMIT = (AW+1)'(MEM_WORDS);
    localparam logic [2:0]  WS        = 3'(WAIT_STATES);

    state_t        state, state_next;
    logic [2:0]    wcnt, wcnt_next;
    logic [AW+1:0] addr_q;
    logic [1:0]    size_q;
    logic [3:0]    lane_mask;
    logic          accept;
    logic          illegal;
    logic          can_accept;
    logic          unused_bits;

    assign unused_bits = ^{HADDRS[31:AW+2], HTRANSS[0]};

    assign accept  = HSELS & HTRANSS[1] & HREADYS;
    assign illegal = (HSIZES > 3'd2)
                   | ((HSIZES == 3'd1) & HADDRS[0])
                   | ((HSIZES == 3'd2) & (|HADDRS[1:0]))
                   | ({1'b0, HADDRS[AW+1:2]} >= MEM_LIMIT);

    assign sram_addr  = addr_q[AW+1:2];
    assign sram_wdata = HWDATAS;

    always_comb begin
        lane_mask = 4'b1111;
        case (size_q)
            2'd0:    lane_mask = 4'b0001 << addr_q[1:0];
            2'd1:    lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
        HRDATAS    = 32'h0;
        sram_cs    = 1'b0;
        sram_we    = 4'b0000;
        can_accept = 1'b0;
        case (state)
            S_IDLE: can_accept = 1'b1;
            S_RD_ISSUE: begin
                HREADYOUTS = 1'b0;
                if (wcnt != 3'd0) begin
                    wcnt_next = wcnt - 3'd1;
                end else begin
                    sram_cs    = 1'b1;
                    state_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                HRDATAS    = sram_rdata;
                can_accept = 1'b1;
            end
            S_WR_WAIT: begin
                HREADYOUTS = (wcnt == 3'd0);
                if (wcnt != 3'd0) begin
                    wcnt_next = wcnt - 3'd1;
                end else begin
                    sram_cs    = 1'b1;
                    sram_we    = lane_mask;
                    can_accept = 1'b1;
                end
            end
            S_ERR1: begin
                HREADYOUTS = 1'b0;
                HRESPS     = 1'b1;
                state_next = S_ERR2;
            end
            S_ERR2: begin
                HRESPS     = 1'b1;
                can_accept = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
        // Completing cycles double as an address phase for the next beat.
        if (can_accept) begin
            if (accept) begin
                wcnt_next = WS;
                if (illegal)      state_next = S_ERR1;
                else if (HWRITES) state_next = S_WR_WAIT;
                else              state_next = S_RD_ISSUE;
            end else begin
                state_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state  <= S_IDLE;
            wcnt   <= 3'd0;
            addr_q <= '0;
            size_q <= 2'd0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
            if (can_accept && accept) begin
                addr_q <= HADDRS[AW+1:0];
                size_q <= HSIZES[1:0];
            end
        end
    end

endmodule

// File: tb/tb_l1_ahb_sram_slave.sv
// tb/tb_l1_ahb_sram_slave.sv - bench for l1_ahb_sram_slave, WAIT_STATES 0 and 3 instances
// Transfers run through a pipelined AHB driver; expectations come from a word-array memory model.
module tb_l1_ahb_sram_slave;

    localparam int AW = 12;
    localparam int MW = 1024;
    localparam int NT = 64;

    logic        clk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] hwdata = 32'h0;
    logic        force_low = 1'b0;
    logic        cur_sel = 1'b0;
    logic        hreadys;

    logic        rdy0, resp0, cs0, rdy3, resp3, cs3;
    logic [31:0] rd0, rd3, wd0, wd3, srd0, srd3;
    logic [3:0]  we0, we3;
    logic [AW-1:0] sa0, sa3;

    logic [31:0] mem0 [4096] = '{default: 32'h0};
    logic [31:0] mem3 [4096] = '{default: 32'h0};
    logic [31:0] ref_mem [2][4096];

    logic        cur_ready, cur_resp, cur_cs;
    logic [31:0] cur_rdata;
    logic [3:0]  cur_we;
    logic [AW-1:0] cur_saddr;

    logic        t_write [NT];
    logic [31:0] t_addr  [NT];
    logic [2:0]  t_size  [NT];
    logic [31:0] t_wdata [NT];
    int          r_waits [NT];
    int          r_cs    [NT];
    logic        r_resp  [NT];
    logic        r_resp1 [NT];
    logic [31:0] r_rdata [NT];
    logic [3:0]  r_we    [NT];
    logic [AW-1:0] r_saddr [NT];
    logic        e_err   [NT];
    int          e_waits [NT];
    logic [31:0] e_rdata [NT];
    logic [3:0]  e_we    [NT];
    int          stray_rdata;
    logic        timed_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign hreadys   = force_low ? 1'b0 : (cur_sel ? rdy3 : rdy0);
    assign cur_ready = cur_sel ? rdy3 : rdy0;
    assign cur_resp  = cur_sel ? resp3 : resp0;
    assign cur_cs    = cur_sel ? cs3 : cs0;
    assign cur_rdata = cur_sel ? rd3 : rd0;
    assign cur_we    = cur_sel ? we3 : we0;
    assign cur_saddr = cur_sel ? sa3 : sa0;

    l1_ahb_sram_slave #(.AW(AW), .MEM_WORDS(MW), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESET(hreset), .HSELS(hsel & ~cur_sel), .HADDRS(haddr),
        .HTRANSS(htrans), .HWRITES(hwrite), .HSIZES(hsize), .HREADYS(hreadys),
        .HWDATAS(hwdata), .HREADYOUTS(rdy0), .HRESPS(resp0), .HRDATAS(rd0),
        .sram_cs(cs0), .sram_we(we0), .sram_addr(sa0), .sram_wdata(wd0),
        .sram_rdata(srd0)
    );

    l1_ahb_sram_slave #(.AW(AW), .MEM_WORDS(MW), .WAIT_STATES(3)) u_ws3 (
        .HCLK(clk), .HRESET(hreset), .HSELS(hsel & cur_sel), .HADDRS(haddr),
        .HTRANSS(htrans), .HWRITES(hwrite), .HSIZES(hsize), .HREADYS(hreadys),
        .HWDATAS(hwdata), .HREADYOUTS(rdy3), .HRESPS(resp3), .HRDATAS(rd3),
        .sram_cs(cs3), .sram_we(we3), .sram_addr(sa3), .sram_wdata(wd3),
        .sram_rdata(srd3)
    );

    always @(posedge clk) begin
        if (cs0) begin
            if (we0 == 4'b0000) srd0 <= mem0[sa0];
            for (int b = 0; b < 4; b++)
                if (we0[b]) mem0[sa0][8*b +: 8] <= wd0[8*b +: 8];
        end
        if (cs3) begin
            if (we3 == 4'b0000) srd3 <= mem3[sa3];
            for (int b = 0; b < 4; b++)
                if (we3[b]) mem3[sa3][8*b +: 8] <= wd3[8*b +: 8];
        end
    end

    // Reference model: walks the transfer list in order against a word array.
    function automatic void model_seq(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            int unsigned a    = t_addr[i];
            int unsigned sz   = t_size[i];
            int unsigned widx = a / 4;
            int unsigned nbytes;
            e_err[i] = (sz > 2) || ((a % (1 << sz)) != 0) || (widx >= MW);
            e_we[i] = 4'b0000;
            e_rdata[i] = 32'h0;
            if (e_err[i]) begin
                e_waits[i] = 1;
            end else if (t_write[i]) begin
                e_waits[i] = (d == 1) ? 3 : 0;
                nbytes = 1 << sz;
                for (int b = 0; b < 4; b++) begin
                    if (b >= int'(a % 4) && b < int'(a % 4 + nbytes)) begin
                        e_we[i][b] = 1'b1;
                        ref_mem[d][widx][8*b +: 8] = t_wdata[i][8*b +: 8];
                    end
                end
            end else begin
                e_waits[i] = (d == 1) ? 4 : 1;
                e_rdata[i] = ref_mem[d][widx];
            end
        end
    endfunction

    task automatic run_seq(input int d, input int n);
        int nxt = 0;
        int dp = -1;
        cur_sel = (d == 1);
        stray_rdata = 0;
        timed_out = 1'b1;
        for (int i = 0; i < n; i++) begin
            r_waits[i] = 0; r_cs[i] = 0; r_resp[i] = 1'b0; r_resp1[i] = 1'b0;
            r_rdata[i] = 32'h0; r_we[i] = 4'b0000; r_saddr[i] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (dp >= 0) begin
                if (cur_cs) begin
                    r_cs[dp]++;
                    r_we[dp] = cur_we;
                    r_saddr[dp] = cur_saddr;
                end
                if (!cur_ready) begin
                    if (r_waits[dp] == 0) r_resp1[dp] = cur_resp;
                    r_waits[dp]++;
                end else begin
                    r_resp[dp] = cur_resp;
                    r_rdata[dp] = cur_rdata;
                end
                hwdata = t_wdata[dp];
            end
            if (cur_rdata !== 32'h0 &&
                !(dp >= 0 && cur_ready && !t_write[dp] && !e_err[dp]))
                stray_rdata++;
            if (cur_ready) begin
                if (nxt < n) begin
                    hsel = 1'b1;
                    htrans = 2'($urandom_range(2, 3));
                    haddr = t_addr[nxt];
                    hwrite = t_write[nxt];
                    hsize = t_size[nxt];
                    dp = nxt;
                    nxt++;
                end else begin
                    hsel = 1'b0;
                    htrans = 2'b00;
                    dp = -1;
                end
            end
            if (dp < 0 && nxt >= n) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rdy0, resp0, cs0, we0, rd0} !== {1'b1, 1'b0, 1'b0, 4'b0000, 32'h0}) begin
            errors++;
            $display("FAIL reset_ws0 got rdy=%b resp=%b cs=%b we=%b rd=%h", rdy0, resp0, cs0, we0, rd0);
        end
        checks++;
        if ({rdy3, resp3, cs3, we3, rd3} !== {1'b1, 1'b0, 1'b0, 4'b0000, 32'h0}) begin
            errors++;
            $display("FAIL reset_ws3 got rdy=%b resp=%b cs=%b we=%b rd=%h", rdy3, resp3, cs3, we3, rd3);
        end
        hreset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        t_write[0] = 1'b1; t_addr[0] = 32'h10; t_size[0] = 3'd2; t_wdata[0] = 32'hDEADBEEF;
        t_write[1] = 1'b0; t_addr[1] = 32'h10; t_size[1] = 3'd2; t_wdata[1] = 32'h0;
        model_seq(0, 2);
        run_seq(0, 2);
        checks++;
        if (timed_out !== 1'b0) begin errors++; $display("FAIL b2b_timeout got %b want 0", timed_out); end
        checks++;
        if (r_waits[0] !== 0 || r_we[0] !== 4'b1111 || r_saddr[0] !== 12'd4 || r_cs[0] !== 1) begin
            errors++;
            $display("FAIL b2b_write waits=%0d we=%b addr=%0d cs=%0d want 0 1111 4 1", r_waits[0], r_we[0], r_saddr[0], r_cs[0]);
        end
        checks++;
        if (r_waits[1] !== 1 || r_rdata[1] !== 32'hDEADBEEF || r_resp[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_read waits=%0d data=%h resp=%b want 1 deadbeef 0", r_waits[1], r_rdata[1], r_resp[1]);
        end
    endtask

    task automatic test_byte_lanes();
        for (int i = 0; i < 4; i++) begin
            t_write[i] = 1'b1; t_addr[i] = 32'h20 + 32'(i); t_size[i] = 3'd0;
            t_wdata[i] = (32'h11 * 32'(i + 1)) << (8 * i);
        end
        t_write[4] = 1'b0; t_addr[4] = 32'h20; t_size[4] = 3'd2; t_wdata[4] = 32'h0;
        model_seq(0, 5);
        run_seq(0, 5);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (r_we[i] !== 4'(1 << i)) begin
                errors++;
                $display("FAIL byte_we[%0d] got %b want %b", i, r_we[i], 4'(1 << i));
            end
        end
        checks++;
        if (r_rdata[4] !== 32'h44332211) begin
            errors++;
            $display("FAIL byte_read got %h want 44332211", r_rdata[4]);
        end
    endtask

    task automatic test_wait_states();
        t_write[0] = 1'b0; t_addr[0] = 32'h40; t_size[0] = 3'd2; t_wdata[0] = 32'h0;
        t_write[1] = 1'b1; t_addr[1] = 32'h40; t_size[1] = 3'd2; t_wdata[1] = 32'hCAFE0123;
        t_write[2] = 1'b0; t_addr[2] = 32'h40; t_size[2] = 3'd2; t_wdata[2] = 32'h0;
        model_seq(1, 3);
        run_seq(1, 3);
        checks++;
        if (r_waits[0] !== 4 || r_cs[0] !== 1) begin
            errors++;
            $display("FAIL ws3_read waits=%0d cs=%0d want 4 1", r_waits[0], r_cs[0]);
        end
        checks++;
        if (r_waits[1] !== 3 || r_cs[1] !== 1) begin
            errors++;
            $display("FAIL ws3_write waits=%0d cs=%0d want 3 1", r_waits[1], r_cs[1]);
        end
        checks++;
        if (r_rdata[2] !== 32'hCAFE0123) begin
            errors++;
            $display("FAIL ws3_readback got %h want cafe0123", r_rdata[2]);
        end
    endtask

    task automatic test_errors();
        t_write[0] = 1'b0; t_addr[0] = 32'h01;       t_size[0] = 3'd1; t_wdata[0] = 32'h0;
        t_write[1] = 1'b1; t_addr[1] = 32'(MW * 4);  t_size[1] = 3'd2; t_wdata[1] = 32'h5;
        t_write[2] = 1'b0; t_addr[2] = 32'h0;        t_size[2] = 3'd3; t_wdata[2] = 32'h0;
        for (int d = 0; d < 2; d++) begin
            model_seq(d, 3);
            run_seq(d, 3);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (r_waits[i] !== 1 || r_resp1[i] !== 1'b1 || r_resp[i] !== 1'b1 || r_cs[i] !== 0) begin
                    errors++;
                    $display("FAIL err[%0d][%0d] waits=%0d resp=%b/%b cs=%0d want 1 1/1 0",
                             d, i, r_waits[i], r_resp1[i], r_resp[i], r_cs[i]);
                end
            end
        end
    endtask

    task automatic test_hready_low();
        int low_cnt = 0;
        int cs_cnt = 0;
        @(negedge clk);
        cur_sel = 1'b0;
        force_low = 1'b1;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b0; hsize = 3'd2;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; force_low = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (!rdy0) low_cnt++;
            if (cs0) cs_cnt++;
            @(negedge clk);
        end
        checks++;
        if (low_cnt !== 0 || cs_cnt !== 0) begin
            errors++;
            $display("FAIL hready_low low_cycles=%0d cs=%0d want 0 0", low_cnt, cs_cnt);
        end
    endtask

    task automatic test_idle_trans();
        cur_sel = 1'b0;
        hsel = 1'b1; htrans = 2'b00; haddr = 32'h10; hwrite = 1'b0; hsize = 3'd2;
        @(negedge clk);
        hsel = 1'b0;
        checks++;
        if ({rdy0, resp0, cs0} !== 3'b100) begin
            errors++;
            $display("FAIL idle_trans rdy=%b resp=%b cs=%b want 1 0 0", rdy0, resp0, cs0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cs_cnt = 0;
        cur_sel = 1'b1;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b0; hsize = 3'd2;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00;
        checks++;
        if (rdy3 !== 1'b0) begin errors++; $display("FAIL rdissue_entry rdy=%b want 0", rdy3); end
        hreset = 1'b1;
        @(negedge clk);
        hreset = 1'b0;
        checks++;
        if ({rdy3, resp3, cs3} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid rdy=%b resp=%b cs=%b want 1 0 0", rdy3, resp3, cs3);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cs3 || !rdy3) cs_cnt++;
        end
        checks++;
        if (cs_cnt !== 0) begin errors++; $display("FAIL reset_mid_after activity=%0d want 0", cs_cnt); end
    endtask

    task automatic test_random();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                int unsigned widx = ($urandom_range(0, 9) == 0) ? $urandom_range(MW, MW + 16)
                                                                 : $urandom_range(0, 31);
                t_write[i] = 1'($urandom_range(0, 1));
                t_size[i]  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                                          : 3'($urandom_range(0, 2));
                t_addr[i]  = 32'(widx * 4 + $urandom_range(0, 3));
                t_wdata[i] = $urandom;
            end
            model_seq(d, 40);
            run_seq(d, 40);
            checks++;
            if (timed_out !== 1'b0 || stray_rdata !== 0) begin
                errors++;
                $display("FAIL rand_run[%0d] timeout=%b stray_rdata=%0d want 0 0", d, timed_out, stray_rdata);
            end
            for (int i = 0; i < 40; i++) begin
                checks++;
                if (r_waits[i] !== e_waits[i] || r_resp[i] !== e_err[i] || r_resp1[i] !== e_err[i] ||
                    r_cs[i] !== (e_err[i] ? 0 : 1)) begin
                    errors++;
                    $display("FAIL rand_ctl[%0d][%0d] waits=%0d resp=%b/%b cs=%0d want %0d %b %0d",
                             d, i, r_waits[i], r_resp1[i], r_resp[i], r_cs[i], e_waits[i], e_err[i], e_err[i] ? 0 : 1);
                end
                if (!e_err[i]) begin
                    checks++;
                    if (r_we[i] !== e_we[i] || r_saddr[i] !== AW'(t_addr[i] / 4) ||
                        (!t_write[i] && r_rdata[i] !== e_rdata[i])) begin
                        errors++;
                        $display("FAIL rand_data[%0d][%0d] we=%b addr=%h data=%h want %b %h %h",
                                 d, i, r_we[i], r_saddr[i], r_rdata[i], e_we[i], AW'(t_addr[i] / 4), e_rdata[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 4096; w++)
                ref_mem[d][w] = 32'h0;
        test_reset();
        test_back_to_back();
        test_byte_lanes();
        test_wait_states();
        test_errors();
        test_hready_low();
        test_idle_trans();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
